keypad_scanner: RTL

Parametrised matrix-keypad scanner for ROWS×COLS keypads. It drives one-hot column strobes, synchronises the row returns, and debounces a single key. It then emits a binary key code with one-cycle press, release and auto-repeat strobes. It replaces the hand-built scan/debounce FSM in the lab top level and feeds the display/storage logic directly.

---
 rtl/keypad_scanner_pkg.sv | 14 +
 rtl/keypad_scanner_if.sv | 26 ++
 rtl/keypad_scanner_sync.sv | 16 +
 rtl/keypad_scanner.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared FSM state type and key-code width helper for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } kp_state_t;

  function automatic int key_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix drive/return and key event bundle
interface keypad_scanner_if
  import keypad_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int KEY_W = key_width(ROWS, COLS)
);
  logic [ROWS-1:0]  row_keys;
  logic [COLS-1:0]  col_keys;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_repeat;
  logic             key_held;
  logic             key_release;

  modport master (
    input  row_keys,
    output col_keys, key_code, key_valid, key_repeat, key_held, key_release
  );

  modport slave (
    output row_keys,
    input  col_keys, key_code, key_valid, key_repeat, key_held, key_release
  );
endinterface

// File: rtl/keypad_scanner_sync.sv
// rtl/keypad_scanner_sync.sv - two-flop synchroniser for the asynchronous row returns
module key_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);
  logic [WIDTH-1:0] meta;

  // No reset: these flops only filter metastability; the FSM owns reset behaviour.
  always_ff @(posedge clk) begin
    meta   <= raw;
    synced <= meta;
  end
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad column scan, single-key debounce, press/repeat/release strobes
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 960000,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);
  localparam int KEY_W   = key_width(ROWS, COLS);
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DWELL_W = $clog2(SCAN_DWELL + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_W   = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [ROWS-1:0]    ROW_ONE    = ROWS'(1);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_FULL   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(REPEAT_CYCLES - 1);

  kp_state_t          state, state_next;
  logic [COL_W-1:0]   col_idx, col_next, col_adv;
  logic [DWELL_W-1:0] dwell_cnt, dwell_next;
  logic [DEB_W-1:0]   deb_cnt, deb_next, rel_cnt, rel_next;
  logic [REP_W-1:0]   rep_cnt, rep_next;
  logic [ROWS-1:0]    latched, latched_next, q_rows;
  logic [KEY_W-1:0]   key_code, code_next;
  logic               key_valid, valid_next, key_repeat, repeat_next;
  logic               key_release, release_next;
  logic               one_hot, match, idle;

  function automatic int onehot_row(input logic [ROWS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  key_sync #(.WIDTH(ROWS)) u_sync (
    .clk    (clk),
    .raw    (kp.row_keys),
    .synced (q_rows)
  );

  assign one_hot = (q_rows != '0) && ((q_rows & (q_rows - ROW_ONE)) == '0);
  assign match   = (q_rows == latched);
  assign idle    = (q_rows == '0);
  assign col_adv = (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);

  always_comb begin
    state_next   = state;
    col_next     = col_idx;
    dwell_next   = dwell_cnt;
    deb_next     = deb_cnt;
    rep_next     = rep_cnt;
    rel_next     = rel_cnt;
    latched_next = latched;
    code_next    = key_code;
    valid_next   = 1'b0;
    repeat_next  = 1'b0;
    release_next = 1'b0;
    unique case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_next = '0;
          if (one_hot) begin
            latched_next = q_rows;
            deb_next     = '0;
            state_next   = DEBOUNCE;
          end else begin
            col_next = col_adv;
          end
        end else begin
          dwell_next = dwell_cnt + DWELL_W'(1);
        end
      end
      DEBOUNCE: begin
        if (!match) begin
          state_next = SCAN;
          col_next   = col_adv;
          dwell_next = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = HOLD;
          code_next  = KEY_W'(onehot_row(latched) * COLS + int'(col_idx));
          valid_next = 1'b1;
          rep_next   = '0;
          rel_next   = '0;
        end else begin
          deb_next = deb_cnt + DEB_W'(1);
        end
      end
      HOLD: begin
        // The release strobe occupies the last HOLD cycle; the column moves on after it.
        if (key_release) begin
          state_next = SCAN;
          col_next   = col_adv;
          dwell_next = '0;
        end else if (rel_cnt == DEB_FULL) begin
          release_next = 1'b1;
        end else begin
          rel_next = idle ? rel_cnt + DEB_W'(1) : '0;
          if (REPEAT_CYCLES > 0 && match) begin
            if (rep_cnt == REP_LAST) begin
              rep_next    = '0;
              valid_next  = 1'b1;
              repeat_next = 1'b1;
            end else begin
              rep_next = rep_cnt + REP_W'(1);
            end
          end
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      col_idx     <= '0;
      dwell_cnt   <= '0;
      deb_cnt     <= '0;
      rep_cnt     <= '0;
      rel_cnt     <= '0;
      latched     <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_next;
      col_idx     <= col_next;
      dwell_cnt   <= dwell_next;
      deb_cnt     <= deb_next;
      rep_cnt     <= rep_next;
      rel_cnt     <= rel_next;
      latched     <= latched_next;
      key_code    <= code_next;
      key_valid   <= valid_next;
      key_repeat  <= repeat_next;
      key_release <= release_next;
    end
  end

  assign kp.col_keys    = COLS'(1) << col_idx;
  assign kp.key_code    = key_code;
  assign kp.key_valid   = key_valid;
  assign kp.key_repeat  = key_repeat;
  assign kp.key_held    = (state == HOLD);
  assign kp.key_release = key_release;
endmodule
